seq_checker: RTL

//  Receive-side partner of the sequence generator. Takes a stream of words and checks that each word

---
 rtl/seq_checker.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/seq_checker.sv
// Receive-side checker for the x[n] = x[n-2] + x[n-3] sequence: self-seeds, locks after a run of
// matches, flywheels through isolated errors and keeps saturating match/error counters.
module seq_checker #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned MAX_ERR  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seq_valid_i,
  input  logic [WIDTH-1:0] seq_i,
  input  logic             resync_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [WIDTH-1:0] expected_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int unsigned RunW  = $clog2(LOCK_CNT + 1);
  localparam int unsigned MissW = $clog2(MAX_ERR + 1);

  typedef enum logic [1:0] {StSeed, StCheck, StLocked} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   h0_q, h1_q, h2_q, h0_d, h1_d, h2_d;
  logic [1:0]         fill_q, fill_d;
  logic [RunW-1:0]    run_q, run_d;
  logic [MissW-1:0]   miss_q, miss_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0]   expected;
  logic               match;
  logic               run_hit;
  logic               miss_hit;
  logic               shift_en;
  logic               clear_hist;
  logic [WIDTH-1:0]   shift_val;

  assign expected = h1_q + h2_q;
  assign match    = (seq_i == expected);
  assign run_hit  = (32'(run_q) + 32'd1 == LOCK_CNT);
  assign miss_hit = (32'(miss_q) + 32'd1 == MAX_ERR);

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    run_d       = run_q;
    miss_d      = miss_q;
    err_d       = 1'b0;
    match_cnt_d = match_cnt_q;
    err_cnt_d   = err_cnt_q;
    shift_en    = 1'b0;
    clear_hist  = 1'b0;
    shift_val   = seq_i;

    if (resync_i) begin
      state_d    = StSeed;
      fill_d     = '0;
      run_d      = '0;
      miss_d     = '0;
      clear_hist = 1'b1;
    end else if (seq_valid_i) begin
      unique case (state_q)
        StSeed: begin
          shift_en = 1'b1;
          fill_d   = fill_q + 2'd1;
          if (fill_q == 2'd2) begin
            state_d = StCheck;
            run_d   = '0;
          end
        end
        StCheck: begin
          // Mismatches still shift, so the latest three words become the new seed.
          shift_en = 1'b1;
          if (match) begin
            run_d = run_q + 1'b1;
            if (run_hit) begin
              state_d = StLocked;
              miss_d  = '0;
            end
          end else begin
            run_d = '0;
          end
        end
        StLocked: begin
          if (match) begin
            shift_en = 1'b1;
            miss_d   = '0;
            if (match_cnt_q != '1) match_cnt_d = match_cnt_q + 1'b1;
          end else begin
            // Flywheel: keep the predicted value so one bad word does not corrupt history.
            err_d     = 1'b1;
            shift_en  = 1'b1;
            shift_val = expected;
            miss_d    = miss_q + 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (miss_hit) begin
              state_d    = StSeed;
              fill_d     = '0;
              miss_d     = '0;
              clear_hist = 1'b1;
            end
          end
        end
        default: begin
          state_d    = StSeed;
          fill_d     = '0;
          clear_hist = 1'b1;
        end
      endcase
    end

    h0_d = h0_q;
    h1_d = h1_q;
    h2_d = h2_q;
    if (clear_hist) begin
      h0_d = '0;
      h1_d = '0;
      h2_d = '0;
    end else if (shift_en) begin
      h2_d = h1_q;
      h1_d = h0_q;
      h0_d = shift_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StSeed;
      h0_q        <= '0;
      h1_q        <= '0;
      h2_q        <= '0;
      fill_q      <= '0;
      run_q       <= '0;
      miss_q      <= '0;
      err_q       <= 1'b0;
      match_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      h0_q        <= h0_d;
      h1_q        <= h1_d;
      h2_q        <= h2_d;
      fill_q      <= fill_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      err_q       <= err_d;
      match_cnt_q <= match_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked_o    = (state_q == StLocked);
  assign err_o       = err_q;
  assign expected_o  = expected;
  assign match_cnt_o = match_cnt_q;
  assign err_cnt_o   = err_cnt_q;

endmodule
